// File: rtl/spi_slave.sv
// SPI responder for the 32-bit link: shifts a word in on si while shifting a preloaded word out on so.
// Everything runs on clk; sck/csn/si are oversampled through synchronizers.
module spi_slave #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sck,
    input  logic             csn,
    input  logic             si,
    output logic             so,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_MAX = FLUSH_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, si_sync;
    logic                   sck_s, csn_s, si_s;
    logic                   sck_d, csn_d;
    logic                   fall_sck, csn_fall, csn_rise;
    logic [FLUSH_W-1:0]     flush_cnt;
    logic                   armed;

    logic [WIDTH-1:0] tx_buf, tx_shift, rx_shift;
    logic             tx_full;
    logic [CNT_W-1:0] bit_cnt;
    logic             start, shift, finish;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign csn_s = csn_sync[SYNC_STAGES-1];
    assign si_s  = si_sync[SYNC_STAGES-1];

    assign fall_sck = sck_d & ~sck_s;
    assign csn_rise = ~csn_d & csn_s;
    // A frame only starts once csn has been seen high after reset, so a frame in flight at release is dropped.
    assign csn_fall = armed & csn_d & ~csn_s;

    assign tx_ready = ~tx_full;
    assign busy     = (state == SHIFT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            si_sync   <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            csn_sync <= {csn_sync[SYNC_STAGES-2:0], csn};
            si_sync  <= {si_sync[SYNC_STAGES-2:0], si};
            sck_d    <= sck_s;
            csn_d    <= csn_s;
            if (flush_cnt != FLUSH_MAX) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else if (csn_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        shift      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift = fall_sck;
                if (csn_rise) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            so          <= 1'b0;
            tx_buf      <= '0;
            tx_full     <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            bit_cnt     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;

            // A word handed over in the same cycle an empty-buffer frame starts waits for the next frame.
            if (start && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_valid && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            if (start) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                if (tx_full) begin
                    tx_shift <= tx_buf;
                    so       <= tx_buf[WIDTH-1];
                end else begin
                    tx_shift    <= '0;
                    so          <= 1'b0;
                    tx_underrun <= 1'b1;
                end
            end

            if (shift) begin
                rx_shift <= {rx_shift[WIDTH-2:0], si_s};
                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                so       <= tx_shift[WIDTH-2];
                if (bit_cnt != CNT_SAT) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            if (finish) begin
                if (bit_cnt == CNT_FULL) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
